data_ram: RTL

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 115 +++++++++++
 1 files changed

// File: rtl/data_ram.sv
// Single-port 32-bit data RAM with a power-up zero-fill sweep, combinational reads,
// and a small MMIO block holding cycle/write/read counters and a sticky error flag.
module data_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] sweep_idx_reg, sweep_idx_next;
    logic [31:0]   cycle_cnt_reg, wr_cnt_reg, rd_cnt_reg;
    logic          err_sticky_reg;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          ram_hit, mmio_hit, misaligned, active, access_err;
    logic          ram_wr, ram_rd, mmio_wr, mmio_rd, err_clear;

    // Address decode; MMIO wins if a high BASE_ADDR ever makes the two windows overlap.
    assign offset     = data_addr_i - BASE_ADDR;
    assign word_idx   = offset[AW+1:2];
    assign mmio_hit   = (data_addr_i[31:4] == 28'hFFF_FFFF);
    assign ram_hit    = (offset[31:AW+2] == '0) && !mmio_hit;
    assign misaligned = |data_addr_i[1:0];
    assign active     = (state_reg == READY) && data_ce_i;
    assign access_err = active && (misaligned || !(ram_hit || mmio_hit));

    assign ram_wr    = active && !access_err && ram_hit && data_we_i;
    assign ram_rd    = active && !access_err && ram_hit && !data_we_i;
    assign mmio_wr   = active && !access_err && mmio_hit && data_we_i;
    assign mmio_rd   = active && !access_err && mmio_hit && !data_we_i;
    assign err_clear = mmio_wr && (data_addr_i[3:2] == 2'd3) && data_i[1];

    assign ready_o = (state_reg == READY);
    assign err_o   = access_err;

    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        if (state_reg == INIT) begin
            sweep_idx_next = sweep_idx_reg + AW'(1);
            if (sweep_idx_reg == AW'(DEPTH_WORDS - 1)) begin
                state_next = READY;
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (ram_rd) begin
            data_o = mem[word_idx];
        end else if (mmio_rd) begin
            case (data_addr_i[3:2])
                2'd0:    data_o = cycle_cnt_reg;
                2'd1:    data_o = wr_cnt_reg;
                2'd2:    data_o = rd_cnt_reg;
                default: data_o = {30'b0, err_sticky_reg, ready_o};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= INIT;
            sweep_idx_reg  <= '0;
            cycle_cnt_reg  <= '0;
            wr_cnt_reg     <= '0;
            rd_cnt_reg     <= '0;
            err_sticky_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
            cycle_cnt_reg <= (state_reg == READY) ? cycle_cnt_reg + 32'd1 : 32'd0;
            if (ram_wr) begin
                wr_cnt_reg <= wr_cnt_reg + 32'd1;
            end
            if (ram_rd) begin
                rd_cnt_reg <= rd_cnt_reg + 32'd1;
            end
            if (access_err) begin
                err_sticky_reg <= 1'b1;
            end else if (err_clear) begin
                err_sticky_reg <= 1'b0;
            end
        end
    end

    // Storage has no reset of its own; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                mem[sweep_idx_reg] <= '0;
            end else if (ram_wr) begin
                mem[word_idx] <= data_i;
            end
        end
    end
endmodule
